// File: rtl/rv64g_pkg.sv
// Shared sizing for the register lock scoreboard.
package rv64g_pkg;
  localparam int unsigned NUM_REGS        = 64;
  localparam int unsigned NUM_OUTSTANDING = 4;
  localparam int unsigned REG_IDX_W       = $clog2(NUM_REGS);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/rv64g_reg_lock_cnt.sv
// Outstanding-write counter for one architectural register.
module rv64g_reg_lock_cnt #(
  parameter int unsigned NOS = 4,
  parameter int unsigned NWB = 2,
  localparam int unsigned CW = $clog2(NOS + 1),
  localparam int unsigned DW = $clog2(NWB + 1),
  localparam int unsigned AW = CW + 2
) (
  input  logic          clk_i,
  input  logic          srst_i,
  input  logic          clear_i,
  input  logic          inc_i,
  input  logic [DW-1:0] dec_i,
  output logic          locked_o,
  output logic          full_o,
  output logic          underflow_c
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] sum_add, sum_net;

  // Net update at widened precision, then clamped to [0, NOS].
  always_comb begin
    cnt_d       = cnt_q;
    sum_add     = AW'(cnt_q) + AW'(inc_i);
    sum_net     = sum_add - AW'(dec_i);
    underflow_c = !clear_i && (AW'(dec_i) > sum_add);
    if (clear_i || underflow_c) begin
      cnt_d = '0;
    end else if (sum_net > AW'(NOS)) begin
      cnt_d = CW'(NOS);
    end else begin
      cnt_d = CW'(sum_net);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign locked_o = (cnt_q != '0);
  assign full_o   = (cnt_q == CW'(NOS));
endmodule

// File: rtl/rv64g_reg_lock_table.sv
// Per-register outstanding-write scoreboard feeding the instruction launcher's lock vector.
module rv64g_reg_lock_table
  import rv64g_pkg::*;
#(
  parameter int unsigned NR  = NUM_REGS,
  parameter int unsigned NOS = NUM_OUTSTANDING,
  parameter int unsigned NWB = 2,
  localparam int unsigned RIW = $clog2(NR),
  localparam int unsigned DW  = $clog2(NWB + 1)
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic                    clear_i,
  input  logic                    lock_valid_i,
  input  logic [RIW-1:0]          lock_rd_i,
  output logic                    lock_ready_o,
  input  logic [NWB-1:0]          rel_valid_i,
  input  logic [NWB-1:0][RIW-1:0] rel_rd_i,
  output logic [NR-1:0]           locks_o,
  output logic                    busy_o,
  output logic                    err_o
);
  logic [NR-1:0]   locked_w, full_w;
  logic [NR-1:1]   inc_w, underflow_w;
  logic [DW-1:0]   dec_w [NR-1:1];
  logic            rel_hit_lock, lock_fire;
  logic            err_q, err_d;

  // Ready gating and decode of the issue/release buses into per-register inc/dec.
  always_comb begin
    rel_hit_lock = 1'b0;
    for (int unsigned p = 0; p < NWB; p++) begin
      if (rel_valid_i[p] && (rel_rd_i[p] == lock_rd_i)) rel_hit_lock = 1'b1;
    end
    lock_ready_o = !(full_w[lock_rd_i] && !rel_hit_lock) && !clear_i && !srst_i;
    lock_fire    = lock_valid_i && lock_ready_o;
    for (int unsigned r = 1; r < NR; r++) begin
      inc_w[r] = lock_fire && (lock_rd_i == RIW'(r));
      dec_w[r] = '0;
      for (int unsigned p = 0; p < NWB; p++) begin
        if (rel_valid_i[p] && (rel_rd_i[p] == RIW'(r))) dec_w[r] = dec_w[r] + DW'(1);
      end
    end
  end

  // x0 has no counter: never locked, never full.
  assign locked_w[0] = 1'b0;
  assign full_w[0]   = 1'b0;

  for (genvar g = 1; g < NR; g++) begin : g_cnt
    rv64g_reg_lock_cnt #(
      .NOS (NOS),
      .NWB (NWB)
    ) u_cnt (
      .clk_i       (clk_i),
      .srst_i      (srst_i),
      .clear_i     (clear_i),
      .inc_i       (inc_w[g]),
      .dec_i       (dec_w[g]),
      .locked_o    (locked_w[g]),
      .full_o      (full_w[g]),
      .underflow_c (underflow_w[g])
    );
  end

  always_comb begin
    err_d = err_q;
    if (|underflow_w) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign locks_o = locked_w;
  assign busy_o  = |locked_w;
  assign err_o   = err_q;
endmodule

// File: tb/tb_rv64g_reg_lock_table.sv
// Directed and model-based checks of the register lock scoreboard.
module tb_rv64g_reg_lock_table;
  logic            clk_i = 1'b0;
  logic            srst_i, clear_i, lock_valid_i;
  logic [5:0]      lock_rd_i;
  logic            lock_ready_o;
  logic [1:0]      rel_valid_i;
  logic [1:0][5:0] rel_rd_i;
  logic [63:0]     locks_o;
  logic            busy_o, err_o;

  int checks = 0;
  int passes = 0;

  rv64g_reg_lock_table #(.NR(64), .NOS(4), .NWB(2)) dut (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .clear_i      (clear_i),
    .lock_valid_i (lock_valid_i),
    .lock_rd_i    (lock_rd_i),
    .lock_ready_o (lock_ready_o),
    .rel_valid_i  (rel_valid_i),
    .rel_rd_i     (rel_rd_i),
    .locks_o      (locks_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Apply current inputs on the next edge, then return inputs to idle.
  task automatic cycle();
    @(posedge clk_i);
    #1;
    srst_i = 1'b0; clear_i = 1'b0; lock_valid_i = 1'b0; rel_valid_i = 2'b00;
  endtask

  task automatic test_reset();
    srst_i = 1'b1; lock_valid_i = 1'b1; lock_rd_i = 6'd5;
    #1;
    checks++;
    if (lock_ready_o !== 1'b0) $display("FAIL ready_in_srst: got %b need 0", lock_ready_o);
    else passes++;
    cycle();
    srst_i = 1'b1;
    cycle();
    #1;
    checks++;
    if (locks_o !== 64'd0 || busy_o !== 1'b0 || err_o !== 1'b0)
      $display("FAIL reset_state: locks=%h busy=%b err=%b need 0/0/0", locks_o, busy_o, err_o);
    else passes++;
    checks++;
    if (lock_ready_o !== 1'b1) $display("FAIL reset_ready: got %b need 1", lock_ready_o);
    else passes++;
  endtask

  task automatic test_basic();
    lock_valid_i = 1'b1; lock_rd_i = 6'd5;
    #1;
    checks++;
    if (locks_o[5] !== 1'b0) $display("FAIL basic_no_bypass: got %b need 0", locks_o[5]);
    else passes++;
    cycle();
    checks++;
    if (locks_o[5] !== 1'b1 || busy_o !== 1'b1)
      $display("FAIL basic_lock5: lock=%b busy=%b need 1/1", locks_o[5], busy_o);
    else passes++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin
      lock_valid_i = 1'b1; lock_rd_i = 6'd7;
      #1;
      checks++;
      if (lock_ready_o !== 1'b1) $display("FAIL sat_ready_%0d: got %b need 1", i, lock_ready_o);
      else passes++;
      cycle();
    end
    lock_valid_i = 1'b1; lock_rd_i = 6'd7;
    #1;
    checks++;
    if (lock_ready_o !== 1'b0) $display("FAIL sat_full_ready: got %b need 0", lock_ready_o);
    else passes++;
    cycle();
    lock_valid_i = 1'b1; lock_rd_i = 6'd7; rel_valid_i = 2'b01; rel_rd_i[0] = 6'd7;
    #1;
    checks++;
    if (lock_ready_o !== 1'b1) $display("FAIL sat_release_ready: got %b need 1", lock_ready_o);
    else passes++;
    cycle();
    lock_rd_i = 6'd7;
    #1;
    checks++;
    if (lock_ready_o !== 1'b0 || locks_o[7] !== 1'b1)
      $display("FAIL sat_still4: ready=%b lock=%b need 0/1", lock_ready_o, locks_o[7]);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      rel_valid_i = 2'b11; rel_rd_i[0] = 6'd7; rel_rd_i[1] = 6'd7;
      cycle();
    end
    checks++;
    if (locks_o[7] !== 1'b0 || err_o !== 1'b0)
      $display("FAIL sat_drain: lock=%b err=%b need 0/0", locks_o[7], err_o);
    else passes++;
  endtask

  task automatic test_dual_release();
    for (int i = 0; i < 2; i++) begin
      lock_valid_i = 1'b1; lock_rd_i = 6'd40;
      cycle();
    end
    checks++;
    if (locks_o[40] !== 1'b1) $display("FAIL dual_locked: got %b need 1", locks_o[40]);
    else passes++;
    rel_valid_i = 2'b11; rel_rd_i[0] = 6'd40; rel_rd_i[1] = 6'd40;
    cycle();
    checks++;
    if (locks_o[40] !== 1'b0 || err_o !== 1'b0)
      $display("FAIL dual_release: lock=%b err=%b need 0/0", locks_o[40], err_o);
    else passes++;
  endtask

  task automatic test_underflow();
    rel_valid_i = 2'b10; rel_rd_i[1] = 6'd12;
    cycle();
    checks++;
    if (err_o !== 1'b1 || locks_o[12] !== 1'b0)
      $display("FAIL uf_set: err=%b lock=%b need 1/0", err_o, locks_o[12]);
    else passes++;
    clear_i = 1'b1;
    cycle();
    checks++;
    if (err_o !== 1'b1 || locks_o !== 64'd0)
      $display("FAIL uf_clear_keeps: err=%b locks=%h need 1/0", err_o, locks_o);
    else passes++;
    cycle();
    checks++;
    if (err_o !== 1'b1) $display("FAIL uf_sticky: got %b need 1", err_o);
    else passes++;
    srst_i = 1'b1;
    cycle();
    checks++;
    if (err_o !== 1'b0) $display("FAIL uf_srst: got %b need 0", err_o);
    else passes++;
  endtask

  task automatic test_x0();
    for (int i = 0; i < 6; i++) begin
      lock_valid_i = 1'b1; lock_rd_i = 6'd0;
      #1;
      checks++;
      if (lock_ready_o !== 1'b1) $display("FAIL x0_ready_%0d: got %b need 1", i, lock_ready_o);
      else passes++;
      cycle();
      checks++;
      if (locks_o[0] !== 1'b0 || busy_o !== 1'b0)
        $display("FAIL x0_lock_%0d: lock=%b busy=%b need 0/0", i, locks_o[0], busy_o);
      else passes++;
    end
    rel_valid_i = 2'b11; rel_rd_i[0] = 6'd0; rel_rd_i[1] = 6'd0;
    cycle();
    checks++;
    if (err_o !== 1'b0) $display("FAIL x0_release_err: got %b need 0", err_o);
    else passes++;
  endtask

  task automatic test_flush();
    logic [63:0] exp_locks;
    exp_locks = 64'd0;
    exp_locks[3] = 1'b1; exp_locks[33] = 1'b1; exp_locks[63] = 1'b1;
    lock_valid_i = 1'b1; lock_rd_i = 6'd3;  cycle();
    lock_valid_i = 1'b1; lock_rd_i = 6'd33; cycle();
    lock_valid_i = 1'b1; lock_rd_i = 6'd63; cycle();
    checks++;
    if (locks_o !== exp_locks) $display("FAIL flush_pre: got %h need %h", locks_o, exp_locks);
    else passes++;
    clear_i = 1'b1; lock_valid_i = 1'b1; lock_rd_i = 6'd9;
    rel_valid_i = 2'b01; rel_rd_i[0] = 6'd3;
    #1;
    checks++;
    if (lock_ready_o !== 1'b0) $display("FAIL flush_ready: got %b need 0", lock_ready_o);
    else passes++;
    cycle();
    checks++;
    if (locks_o !== 64'd0 || busy_o !== 1'b0 || err_o !== 1'b0)
      $display("FAIL flush_post: locks=%h busy=%b err=%b need 0/0/0", locks_o, busy_o, err_o);
    else passes++;
  endtask

  task automatic test_random();
    int          mcnt [64];
    logic        merr;
    logic        lv, clr, rst, hit, exp_ready, fire;
    logic [5:0]  rd;
    logic [1:0]  rv;
    logic [5:0]  rr [2];
    logic [63:0] exp_locks;
    int          n;
    int          rand_fails;
    rand_fails = 0;
    srst_i = 1'b1;
    cycle();
    for (int r = 0; r < 64; r++) mcnt[r] = 0;
    merr = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      lv  = ($urandom_range(0, 9) < 6);
      rd  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      clr = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 999) == 0);
      for (int p = 0; p < 2; p++) begin
        rv[p] = ($urandom_range(0, 9) < 3);
        rr[p] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      end
      srst_i = rst; clear_i = clr; lock_valid_i = lv; lock_rd_i = rd;
      rel_valid_i = rv; rel_rd_i[0] = rr[0]; rel_rd_i[1] = rr[1];
      #1;
      hit = (rv[0] && rr[0] == rd) || (rv[1] && rr[1] == rd);
      exp_ready = !(rd != 6'd0 && mcnt[rd] == 4 && !hit) && !clr && !rst;
      fire = lv && exp_ready;
      checks++;
      if (lock_ready_o !== exp_ready) begin
        if (rand_fails < 10)
          $display("FAIL rand_ready cyc%0d: got %b need %b", cyc, lock_ready_o, exp_ready);
        rand_fails++;
      end else passes++;
      if (rst) begin
        for (int r = 0; r < 64; r++) mcnt[r] = 0;
        merr = 1'b0;
      end else if (clr) begin
        for (int r = 0; r < 64; r++) mcnt[r] = 0;
      end else begin
        for (int r = 1; r < 64; r++) begin
          n = mcnt[r] + ((fire && rd == 6'(r)) ? 1 : 0);
          for (int p = 0; p < 2; p++) if (rv[p] && rr[p] == 6'(r)) n = n - 1;
          if (n < 0) begin n = 0; merr = 1'b1; end
          if (n > 4) n = 4;
          mcnt[r] = n;
        end
      end
      cycle();
      for (int r = 0; r < 64; r++) exp_locks[r] = (mcnt[r] != 0);
      checks++;
      if (locks_o !== exp_locks || busy_o !== (|exp_locks) || err_o !== merr) begin
        if (rand_fails < 10)
          $display("FAIL rand_state cyc%0d: locks=%h busy=%b err=%b need %h/%b/%b",
                   cyc, locks_o, busy_o, err_o, exp_locks, |exp_locks, merr);
        rand_fails++;
      end else passes++;
    end
  endtask

  initial begin
    srst_i = 1'b0; clear_i = 1'b0; lock_valid_i = 1'b0; lock_rd_i = '0;
    rel_valid_i = '0; rel_rd_i = '0;
    @(posedge clk_i);
    #1;
    test_reset();
    test_basic();
    test_saturation();
    test_dual_release();
    test_underflow();
    test_x0();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
